// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Transfer-size encodings, FSM states, requester ids, length helper.
package mem_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Size code 3 is not a legal access; it is handled as a word.
    function automatic logic [2:0] xfer_len(input logic [1:0] size);
        case (size)
            SIZE_B:  xfer_len = 3'd1;
            SIZE_H:  xfer_len = 3'd2;
            SIZE_W:  xfer_len = 3'd4;
            default: xfer_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Grant logic evaluated in the controller's IDLE cycle.
// Ports: i_en (controller idle), i_if_req/i_if_flush/i_mem_req requests,
//        o_gnt (a grant is issued), o_gnt_id (REQ_IF or REQ_MEM);
//        clk/rst exist only when MEMCTRL_RR_ARB_EN is defined.
// MEMCTRL_RR_ARB_EN: round-robin between IF and MEM on a tie,
// otherwise MEM always wins a tie.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
`ifdef MEMCTRL_RR_ARB_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic i_en,
    input  logic i_if_req,
    input  logic i_if_flush,
    input  logic i_mem_req,
    output logic o_gnt,
    output logic o_gnt_id
);

    logic w_if_ok;

    // A fetch that is being flushed in the same cycle is stale.
    assign w_if_ok = i_if_req && !i_if_flush;

`ifdef MEMCTRL_RR_ARB_EN
    logic r_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last <= REQ_IF;
        end else if (o_gnt) begin
            r_last <= o_gnt_id;
        end
    end

    always_comb begin
        o_gnt    = i_en && (i_mem_req || w_if_ok);
        o_gnt_id = i_mem_req ? REQ_MEM : REQ_IF;
        if (i_mem_req && w_if_ok) begin
            o_gnt_id = (r_last == REQ_IF) ? REQ_MEM : REQ_IF;
        end
    end
`else
    always_comb begin
        o_gnt    = i_en && (i_mem_req || w_if_ok);
        o_gnt_id = i_mem_req ? REQ_MEM : REQ_IF;
    end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates IF fetches and MEM
// loads/stores onto one 8-bit RAM port, little-endian.
// Ports: clk, rst (sync, active-low); IF side if_req/if_addr/if_flush
//        -> if_data/if_done; MEM side mem_req/mem_we/mem_size/mem_addr/
//        mem_wdata -> mem_rdata/mem_done; RAM side ram_a/ram_dout/ram_wr,
//        ram_din (one-cycle read latency); stall_if/stall_mem to stall_ctrl.
// MEMCTRL_RR_ARB_EN selects round-robin arbitration (see mem_ctrl_arb).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din,
    output logic              stall_if,
    output logic              stall_mem
);

    state_t            r_state;
    state_t            w_next;
    logic              r_req;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_len;
    logic [2:0]        r_idx;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic [31:0]       r_if_data;
    logic [31:0]       r_mem_rdata;
    logic              r_if_done;
    logic              r_mem_done;
    logic [ADDR_W-1:0] r_ram_a;
    logic [7:0]        r_ram_dout;
    logic              r_ram_wr;

    logic              w_gnt;
    logic              w_gnt_id;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [2:0]        w_len;
    logic              w_abort;
    logic              w_rd_last;
    logic              w_wr_last;
    logic              w_more;
    logic [1:0]        w_lane;
    logic [1:0]        w_wr_lane;
    logic [31:0]       w_buf_next;
    logic [ADDR_W-1:0] w_addr_next;

    mem_ctrl_arb u_arb (
`ifdef MEMCTRL_RR_ARB_EN
        .clk        (clk),
        .rst        (rst),
`endif
        .i_en       (r_state == ST_IDLE),
        .i_if_req   (if_req),
        .i_if_flush (if_flush),
        .i_mem_req  (mem_req),
        .o_gnt      (w_gnt),
        .o_gnt_id   (w_gnt_id)
    );

    assign w_we   = (w_gnt_id == REQ_MEM) && mem_we;
    assign w_addr = (w_gnt_id == REQ_MEM) ? mem_addr : if_addr;
    assign w_len  = (w_gnt_id == REQ_MEM) ? xfer_len(mem_size) : 3'd4;

    // In READ, r_idx counts cycles: address r_idx is on ram_a while the
    // byte for address r_idx-1 arrives on ram_din. The last READ cycle
    // (r_idx == r_len) only captures.
    assign w_abort     = (r_req == REQ_IF) && if_flush;
    assign w_rd_last   = (r_idx == r_len);
    assign w_wr_last   = (r_idx == r_len - 3'd1);
    assign w_more      = (r_idx + 3'd1) < r_len;
    assign w_lane      = r_idx[1:0] - 2'd1;
    assign w_wr_lane   = r_idx[1:0] + 2'd1;
    assign w_addr_next = r_base + ADDR_W'(r_idx + 3'd1);

    always_comb begin
        w_buf_next = r_buf;
        w_buf_next[{w_lane, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_gnt) begin
                    w_next = w_we ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (w_abort) begin
                    w_next = ST_IDLE;
                end else if (w_rd_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (w_wr_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_req       <= REQ_IF;
            r_base      <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_ram_a     <= '0;
            r_ram_dout  <= '0;
            r_ram_wr    <= 1'b0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_gnt) begin
                        r_req   <= w_gnt_id;
                        r_base  <= w_addr;
                        r_len   <= w_len;
                        r_wdata <= mem_wdata;
                        r_idx   <= '0;
                        r_buf   <= '0;
                        r_ram_a <= w_addr;
                        if (w_we) begin
                            r_ram_wr   <= 1'b1;
                            r_ram_dout <= mem_wdata[7:0];
                        end
                    end
                end
                ST_READ: begin
                    if (!w_abort) begin
                        r_idx <= r_idx + 3'd1;
                        if (r_idx != 3'd0) begin
                            r_buf <= w_buf_next;
                        end
                        if (w_more) begin
                            r_ram_a <= w_addr_next;
                        end
                        if (w_rd_last) begin
                            if (r_req == REQ_IF) begin
                                r_if_data <= w_buf_next;
                                r_if_done <= 1'b1;
                            end else begin
                                r_mem_rdata <= w_buf_next;
                                r_mem_done  <= 1'b1;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_wr_last) begin
                        r_ram_wr   <= 1'b0;
                        r_mem_done <= 1'b1;
                    end else begin
                        r_idx      <= r_idx + 3'd1;
                        r_ram_a    <= w_addr_next;
                        r_ram_dout <= r_wdata[{w_wr_lane, 3'b000} +: 8];
                    end
                end
                ST_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign if_data   = r_if_data;
    assign if_done   = r_if_done;
    assign mem_rdata = r_mem_rdata;
    assign mem_done  = r_mem_done;
    assign ram_a     = r_ram_a;
    assign ram_dout  = r_ram_dout;
    assign ram_wr    = r_ram_wr;
    assign stall_if  = if_req && !if_done;
    assign stall_mem = mem_req && !mem_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: RAM environment, reference byte
// image and transaction-level expectations, plus a per-cycle monitor.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;
    logic        stall_if;
    logic        stall_mem;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_data   (if_data),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_a     (ram_a),
        .ram_dout  (ram_dout),
        .ram_wr    (ram_wr),
        .ram_din   (ram_din),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    bit last_mem = 1'b0;

    logic [7:0] ram [4096];
    logic [7:0] ref_mem [4096];

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t wq[$];

    always @(posedge clk) begin
        ram_din <= ram[ram_a[11:0]];
        if (ram_wr) ram[ram_a[11:0]] = ram_dout;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = ref_mem[int'(a[11:0]) + i];
        return r;
    endfunction

    task automatic store_ref(input logic [31:0] a, input int n,
                             input logic [31:0] wd);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.a = a + 32'(i);
            w.d = wd[8*i +: 8];
            wq.push_back(w);
            ref_mem[int'(a[11:0]) + i] = wd[8*i +: 8];
        end
    endtask

    // Per-cycle monitor: stall rules and every RAM write.
    always @(negedge clk) begin
        if (mon_en) begin
            chk1("stall_if", stall_if, if_req && !if_done);
            chk1("stall_mem", stall_mem, mem_req && !mem_done);
            if (wq.size() == 0) begin
                chk1("ram_wr_unexpected", ram_wr, 1'b0);
            end else if (ram_wr) begin
                wr_t w;
                w = wq.pop_front();
                chk("ram_wr_addr", ram_a, w.a);
                chk("ram_wr_byte", {24'h0, ram_dout}, {24'h0, w.d});
            end
        end
    end

    // One or two simultaneous requests, checked for grant order,
    // done latency, data and write timing.
    task automatic run2(input bit do_if, input logic [31:0] ia,
                        input bit do_m, input bit we, input logic [1:0] sz,
                        input logic [31:0] ma, input logic [31:0] wd,
                        output logic [31:0] gi, output logic [31:0] gm);
        int n_m, lat_m, exp_i, exp_m, ms, gi_c, gm_c, c, spur, wr_bad;
        logic [31:0] ed_i, ed_m;
        bit mem_first, exp_wr;
        n_m   = nbytes(sz);
        lat_m = we ? n_m + 1 : n_m + 2;
        if (do_if && do_m) begin
`ifdef MEMCTRL_RR_ARB_EN
            mem_first = !last_mem;
`else
            mem_first = 1'b1;
`endif
        end else begin
            mem_first = do_m;
        end
        ed_i = '0;
        ed_m = '0;
        if (mem_first) begin
            if (we) store_ref(ma, n_m, wd);
            else ed_m = rd_ref(ma, n_m);
            if (do_if) ed_i = rd_ref(ia, 4);
        end else begin
            if (do_if) ed_i = rd_ref(ia, 4);
            if (do_m && we) store_ref(ma, n_m, wd);
            else if (do_m) ed_m = rd_ref(ma, n_m);
        end
        ms    = mem_first ? 0 : 7;
        exp_m = ms + lat_m;
        exp_i = (mem_first && do_m) ? lat_m + 1 + 6 : 6;
        if (do_if) begin
            if_req  = 1'b1;
            if_addr = ia;
        end
        if (do_m) begin
            mem_req   = 1'b1;
            mem_we    = we;
            mem_size  = sz;
            mem_addr  = ma;
            mem_wdata = wd;
        end
        gi = '0; gm = '0; gi_c = -1; gm_c = -1;
        c = 0; spur = 0; wr_bad = 0;
        while (c < 60 && !((!do_if || gi_c >= 0) && (!do_m || gm_c >= 0))) begin
            @(negedge clk);
            exp_wr = do_m && we && c >= ms + 1 && c <= ms + n_m;
            if (ram_wr !== exp_wr) wr_bad++;
            if (if_done) begin
                if (!do_if || gi_c >= 0) spur++;
                else begin gi_c = c; gi = if_data; end
            end
            if (mem_done) begin
                if (!do_m || gm_c >= 0) spur++;
                else begin gm_c = c; gm = mem_rdata; end
            end
            @(posedge clk);
            #1;
            if (gi_c == c) if_req = 1'b0;
            if (gm_c == c) mem_req = 1'b0;
            c++;
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
        if (do_if) begin
            chk("if_done_cycle", 32'(gi_c), 32'(exp_i));
            chk("if_data", gi, ed_i);
        end
        if (do_m) begin
            chk("mem_done_cycle", 32'(gm_c), 32'(exp_m));
            if (!we) chk("mem_rdata", gm, ed_m);
        end
        chk("ram_wr_timing_errs", 32'(wr_bad), 32'd0);
        chk("spurious_done", 32'(spur), 32'd0);
        if (do_if && do_m) last_mem = !mem_first;
        else last_mem = do_m;
    endtask

    logic [31:0] gi, gm, v, fd;
    logic [1:0]  rsz;
    int          fc, fspur, bad;

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = '0;
        mem_addr = '0; mem_wdata = '0; ram_din = '0;
        for (int i = 0; i < 4096; i++) begin
            v = $urandom;
            ram[i] = v[7:0];
            ref_mem[i] = v[7:0];
        end
        ram[256] = 8'h13; ram[257] = 8'h05; ram[258] = 8'h00; ram[259] = 8'h00;
        ref_mem[256] = 8'h13; ref_mem[257] = 8'h05;
        ref_mem[258] = 8'h00; ref_mem[259] = 8'h00;
        ram[770] = 8'h77; ref_mem[770] = 8'h77;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_ram_a", ram_a, 32'h0);
        chk("rst_ram_dout", {24'h0, ram_dout}, 32'h0);
        chk1("rst_ram_wr", ram_wr, 1'b0);
        chk1("rst_if_done", if_done, 1'b0);
        chk1("rst_mem_done", mem_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;

        run2(1, 32'h100, 0, 0, 2'd0, 32'h0, 32'h0, gi, gm);
        chk("lit_fetch_0x100", gi, 32'h00000513);

        run2(0, 32'h0, 1, 1, 2'd2, 32'h200, 32'hDEADBEEF, gi, gm);
        chk("lit_store_word", {ram[515], ram[514], ram[513], ram[512]},
            32'hDEADBEEF);

        run2(0, 32'h0, 1, 0, 2'd0, 32'h202, 32'h0, gi, gm);
        chk("lit_load_byte", gm, 32'h000000AD);

        run2(0, 32'h0, 1, 1, 2'd1, 32'h300, 32'hFFFF1234, gi, gm);
        chk("lit_store_half", {8'h0, ram[770], ram[769], ram[768]},
            32'h00771234);

        run2(1, 32'h100, 1, 0, 2'd2, 32'h200, 32'h0, gi, gm);
        chk("lit_dual_if", gi, 32'h00000513);
        chk("lit_dual_mem", gm, 32'hDEADBEEF);
        run2(1, 32'h200, 1, 0, 2'd1, 32'h100, 32'h0, gi, gm);
        chk("lit_dual2_mem", gm, 32'h00000513);

        // Fetch flushed at T+3, redirected fetch granted at T+4.
        fd = rd_ref(32'h104, 4);
        if_req = 1'b1; if_addr = 32'h100;
        fc = -1; fspur = 0;
        for (int c = 0; c < 20 && fc < 0; c++) begin
            @(negedge clk);
            if (if_done) begin
                if (c == 10) fc = c;
                else fspur++;
                gi = if_data;
            end
            if (mem_done) fspur++;
            @(posedge clk);
            #1;
            if (c == 2) if_flush = 1'b1;
            if (c == 3) begin if_flush = 1'b0; if_addr = 32'h104; end
        end
        if_req = 1'b0;
        chk("flush_done_cycle", 32'(fc), 32'd10);
        chk("flush_spurious_done", 32'(fspur), 32'd0);
        chk("flush_refetch_data", gi, fd);
        last_mem = 1'b0;

        // Reset in the middle of a word store.
        store_ref(32'h400, 2, 32'hCAFEF00D);
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2;
        mem_addr = 32'h400; mem_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        mem_req = 1'b0;
        @(negedge clk);
        chk("mrst_if_data", if_data, 32'h0);
        chk("mrst_mem_rdata", mem_rdata, 32'h0);
        chk("mrst_ram_a", ram_a, 32'h0);
        chk("mrst_ram_dout", {24'h0, ram_dout}, 32'h0);
        chk1("mrst_ram_wr", ram_wr, 1'b0);
        chk1("mrst_mem_done", mem_done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        last_mem = 1'b0;
        run2(1, 32'h100, 0, 0, 2'd0, 32'h0, 32'h0, gi, gm);

        for (int k = 0; k < 80; k++) begin
            int kind;
            kind = $urandom_range(0, 3);
            v = $urandom;
            rsz = v[1:0];
            case (kind)
                0: run2(1, 32'($urandom_range(0, 4092)), 0, 0, rsz,
                        32'h0, 32'h0, gi, gm);
                1: run2(0, 32'h0, 1, 0, rsz, 32'($urandom_range(0, 4092)),
                        32'h0, gi, gm);
                2: run2(0, 32'h0, 1, 1, rsz, 32'($urandom_range(0, 4092)),
                        $urandom, gi, gm);
                default: run2(1, 32'($urandom_range(0, 4092)), 1, v[2], rsz,
                              32'($urandom_range(0, 4092)), $urandom, gi, gm);
            endcase
        end

        repeat (2) @(posedge clk);
        #1;
        chk("pending_writes", 32'(wq.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk("ram_image_diffs", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
